// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store unit in front of a word-only, single-cycle data memory.
// Sub-word loads are lane-selected and extended; sub-word stores run as a
// read-modify-write over two memory cycles. The core is stalled (req_ready
// low) whenever the unit is not idle.
// Optional feature: define LSU_PERF_CNT_EN to add load/store/error counters.

module lsu_rmw #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  cnt_load,
  output logic [CNT_WIDTH-1:0]  cnt_store,
  output logic [CNT_WIDTH-1:0]  cnt_err
`endif
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LD,
    ST,
    RMW_RD,
    RMW_WR,
    DONE
  } state_t;

  state_t                state;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  logic                  req_err;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [31:0]           load_data;
  logic [31:0]           merged;

  assign req_ready = (state == IDLE);

  // Illegal encodings, stores with unsigned widths and misaligned H/W accesses
  assign req_err = (req_funct3 == 3'b011) ||
                   (req_funct3[2:1] == 2'b11) ||
                   (req_we && req_funct3[2]) ||
                   ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));

  // Pick the addressed lane out of the memory word and extend it for the load result
  always_comb begin
    byte_sel  = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (funct3_q)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h000000, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0000, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  // Overlay the store byte/halfword onto the word just read from memory
  always_comb begin
    merged = mem_rdata;
    if (funct3_q[1:0] == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  // Main sequencer; every memory and response output is a registered FSM output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            funct3_q   <= req_funct3;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            resp_rdata <= 32'h0;
            resp_err   <= req_err;
            if (req_err) begin
              resp_valid <= 1'b1;
              state      <= DONE;
            end else begin
              mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              if (!req_we) begin
                mem_read <= 1'b1;
                state    <= LD;
              end else if (req_funct3 == F3_W) begin
                mem_write <= 1'b1;
                mem_wdata <= req_wdata;
                state     <= ST;
              end else begin
                mem_read <= 1'b1;
                state    <= RMW_RD;
              end
            end
          end
        end
        LD: begin
          resp_rdata <= we_q ? 32'h0 : load_data;
          mem_read   <= 1'b0;
          mem_addr   <= '0;
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        ST: begin
          mem_write  <= 1'b0;
          mem_wdata  <= 32'h0;
          mem_addr   <= '0;
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        RMW_RD: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b1;
          mem_wdata <= merged;
          state     <= RMW_WR;
        end
        RMW_WR: begin
          mem_write  <= 1'b0;
          mem_wdata  <= 32'h0;
          mem_addr   <= '0;
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          mem_addr   <= '0;
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  // Count each completed request once, in its response cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_load  <= '0;
      cnt_store <= '0;
      cnt_err   <= '0;
    end else if (state == DONE) begin
      if (resp_err) begin
        cnt_err <= cnt_err + 1'b1;
      end else if (we_q) begin
        cnt_store <= cnt_store + 1'b1;
      end else begin
        cnt_load <= cnt_load + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lsu_rmw.sv
// tb_lsu_rmw: self-checking bench for lsu_rmw. Directed table from the
// worked examples, a mid-RMW reset sequence, then random traffic checked
// against a byte-addressed reference memory. Define LSU_PERF_CNT_EN to
// also check the access counters.

module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] cnt_load;
  logic [31:0] cnt_store;
  logic [31:0] cnt_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  lsu_rmw #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef LSU_PERF_CNT_EN
    ,
    .cnt_load   (cnt_load),
    .cnt_store  (cnt_store),
    .cnt_err    (cnt_err)
`endif
  );

  always #5 clk = ~clk;

  // Word memory seen by the DUT: combinational read, clocked write
  logic [31:0] mem [0:255];
  logic        mem_init = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] w;
    w = i;
    if (i == 16) return 32'h8899AABB;
    return (w * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  assign mem_rdata = mem[mem_addr[9:2]];

  // Memory model: bulk init on request, otherwise accept DUT writes
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  // Reference model: byte-addressed memory and per-type completion counts
  logic [7:0] ref_mem [0:1023];
  int ref_loads = 0;
  int ref_stores = 0;
  int ref_errs = 0;

  function automatic int model_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
    if (we && (f3 == 3'b100 || f3 == 3'b101)) return 1'b1;
    if ((f3 == 3'b001 || f3 == 3'b101) && (addr % 2 != 0)) return 1'b1;
    if (f3 == 3'b010 && (addr % 4 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    int n;
    logic [31:0] v;
    n = model_size(f3);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v + (32'(ref_mem[(addr + i) % 1024]) << (8 * i));
    if ((f3 == 3'b000 || f3 == 3'b001) && v[8 * n - 1]) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  function automatic logic [31:0] model_store_word(input logic [2:0] f3, input logic [31:0] addr,
                                                   input logic [31:0] wdata);
    int n;
    int base;
    logic [31:0] w;
    n = model_size(f3);
    base = int'(addr % 1024) - int'(addr % 4);
    w = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (base + b >= int'(addr % 1024) && base + b < int'(addr % 1024) + n)
        w = w + (((wdata >> (8 * (base + b - int'(addr % 1024)))) & 32'hFF) << (8 * b));
      else
        w = w + (32'(ref_mem[base + b]) << (8 * b));
    end
    return w;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    for (int i = 0; i < model_size(f3); i++) ref_mem[(addr + i) % 1024] = 8'((wdata >> (8 * i)) & 32'hFF);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Observations gathered by applyStimulus for one transaction
  int          obs_lat;
  int          obs_rd;
  int          obs_wr;
  int          obs_both;
  int          obs_busy_ready;
  int          obs_idle_bus;
  logic        obs_timeout;
  logic [31:0] obs_rdata;
  logic        obs_err;
  logic [31:0] obs_raddr;
  logic [31:0] obs_waddr;
  logic [31:0] obs_wdata;

  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata);
    int waitc;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    waitc = 0;
    while (!req_ready && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    obs_timeout    = !req_ready;
    obs_idle_bus   = (mem_read || mem_write) ? 1 : 0;
    obs_rd         = 0;
    obs_wr         = 0;
    obs_both       = 0;
    obs_busy_ready = 0;
    obs_raddr      = 32'h0;
    obs_waddr      = 32'h0;
    obs_wdata      = 32'h0;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    obs_lat = 0;
    do begin
      @(negedge clk);
      obs_lat++;
      if (mem_read) begin
        obs_rd++;
        obs_raddr = mem_addr;
      end
      if (mem_write) begin
        obs_wr++;
        obs_waddr = mem_addr;
        obs_wdata = mem_wdata;
      end
      if (mem_read && mem_write) obs_both++;
      if (req_ready && !resp_valid) obs_busy_ready++;
    end while (!resp_valid && obs_lat < 8);
    obs_timeout = obs_timeout || !resp_valid;
    obs_rdata   = resp_rdata;
    obs_err     = resp_err;
  endtask

  // Run one request and compare everything observable against the expectations
  task automatic checkTxn(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input logic [31:0] exp_wdata);
    int exp_rd;
    int exp_wr;
    exp_rd = (!exp_err && (!we || f3 != 3'b010)) ? 1 : 0;
    exp_wr = (!exp_err && we) ? 1 : 0;
    applyStimulus(we, f3, addr, wdata);
    checkOutput({name, " timeout"}, 32'(obs_timeout), 32'h0);
    checkOutput({name, " latency"}, obs_lat, exp_lat);
    checkOutput({name, " resp_err"}, 32'(obs_err), 32'(exp_err));
    checkOutput({name, " resp_rdata"}, obs_rdata, exp_rdata);
    checkOutput({name, " read cycles"}, obs_rd, exp_rd);
    checkOutput({name, " write cycles"}, obs_wr, exp_wr);
    checkOutput({name, " rd&wr overlap"}, obs_both, 0);
    checkOutput({name, " ready while busy"}, obs_busy_ready, 0);
    checkOutput({name, " bus active in idle"}, obs_idle_bus, 0);
    if (exp_rd != 0) checkOutput({name, " read addr"}, obs_raddr, addr & 32'hFFFFFFFC);
    if (exp_wr != 0) begin
      checkOutput({name, " write addr"}, obs_waddr, addr & 32'hFFFFFFFC);
      checkOutput({name, " write data"}, obs_wdata, exp_wdata);
      model_store(f3, addr, wdata);
    end
    if (exp_err) ref_errs++;
    else if (we) ref_stores++;
    else ref_loads++;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] w;
    logic        found;
    int          waitc;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_rdata;
    int          r_lat;

    for (int i = 0; i < 256; i++) begin
      w = init_word(i);
      for (int b = 0; b < 4; b++) ref_mem[4 * i + b] = w[8 * b +: 8];
    end
    mem_init = 1'b1;
    @(negedge clk);
    mem_init = 1'b0;
    @(negedge clk);

    checkOutput("reset resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("reset resp_err", 32'(resp_err), 32'h0);
    checkOutput("reset resp_rdata", resp_rdata, 32'h0);
    checkOutput("reset mem_read", 32'(mem_read), 32'h0);
    checkOutput("reset mem_write", 32'(mem_write), 32'h0);
    checkOutput("reset mem_addr", mem_addr, 32'h0);
    checkOutput("reset mem_wdata", mem_wdata, 32'h0);
    checkOutput("reset req_ready", 32'(req_ready), 32'h1);
    rst_n = 1'b1;

    vecs.push_back('{"LB 0x41",   1'b0, 3'b000, 32'h41, 32'h0,        32'hFFFFFFAA, 1'b0, 2, 32'h0});
    vecs.push_back('{"LBU 0x43",  1'b0, 3'b100, 32'h43, 32'h0,        32'h00000088, 1'b0, 2, 32'h0});
    vecs.push_back('{"LHU 0x42",  1'b0, 3'b101, 32'h42, 32'h0,        32'h00008899, 1'b0, 2, 32'h0});
    vecs.push_back('{"LW 0x40",   1'b0, 3'b010, 32'h40, 32'h0,        32'h8899AABB, 1'b0, 2, 32'h0});
    vecs.push_back('{"LH 0x40",   1'b0, 3'b001, 32'h40, 32'h0,        32'hFFFFAABB, 1'b0, 2, 32'h0});
    vecs.push_back('{"SB 0x42",   1'b1, 3'b000, 32'h42, 32'h12345677, 32'h0,        1'b0, 3, 32'h8877AABB});
    vecs.push_back('{"LW 0x40b",  1'b0, 3'b010, 32'h40, 32'h0,        32'h8877AABB, 1'b0, 2, 32'h0});
    vecs.push_back('{"SW 0x44",   1'b1, 3'b010, 32'h44, 32'hDEADBEEF, 32'h0,        1'b0, 2, 32'hDEADBEEF});
    vecs.push_back('{"LW 0x44",   1'b0, 3'b010, 32'h44, 32'h0,        32'hDEADBEEF, 1'b0, 2, 32'h0});
    vecs.push_back('{"SH 0x46",   1'b1, 3'b001, 32'h46, 32'h1234CAFE, 32'h0,        1'b0, 3, 32'hCAFEBEEF});
    vecs.push_back('{"LW 0x44b",  1'b0, 3'b010, 32'h44, 32'h0,        32'hCAFEBEEF, 1'b0, 2, 32'h0});
    vecs.push_back('{"LW 0x42e",  1'b0, 3'b010, 32'h42, 32'h0,        32'h0,        1'b1, 1, 32'h0});
    vecs.push_back('{"SH 0x45e",  1'b1, 3'b001, 32'h45, 32'h5555,     32'h0,        1'b1, 1, 32'h0});
    vecs.push_back('{"F3 011e",   1'b0, 3'b011, 32'h40, 32'h0,        32'h0,        1'b1, 1, 32'h0});
    vecs.push_back('{"SBU e",     1'b1, 3'b100, 32'h40, 32'h77,       32'h0,        1'b1, 1, 32'h0});
    vecs.push_back('{"LHU 0x43e", 1'b0, 3'b101, 32'h43, 32'h0,        32'h0,        1'b1, 1, 32'h0});
    vecs.push_back('{"LBU after", 1'b0, 3'b100, 32'h41, 32'h0,        32'h000000AA, 1'b0, 2, 32'h0});

    foreach (vecs[i])
      checkTxn(vecs[i].name, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
               vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_wdata);

    // Reset while an SB sits in its write cycle: the write must vanish
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h49;
    req_wdata  = 32'h000000A5;
    waitc = 0;
    while (!req_ready && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      if (mem_write) found = 1'b1;
    end
    checkOutput("rst-rmw reached write", 32'(found), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst-rmw mem_write", 32'(mem_write), 32'h0);
    checkOutput("rst-rmw mem_read", 32'(mem_read), 32'h0);
    checkOutput("rst-rmw resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("rst-rmw mem_addr", mem_addr, 32'h0);
    ref_loads = 0;
    ref_stores = 0;
    ref_errs = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("rst-rmw held resp_valid", 32'(resp_valid), 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst-rmw req_ready", 32'(req_ready), 32'h1);
    checkOutput("rst-rmw resp_valid after", 32'(resp_valid), 32'h0);
    checkTxn("LW 0x48 untouched", 1'b0, 3'b010, 32'h48, 32'h0, model_load(3'b010, 32'h48), 1'b0, 2, 32'h0);

    // Random traffic against the reference model
    for (int t = 0; t < 150; t++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_f3    = 3'($urandom_range(0, 7));
      r_addr  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(32'h40, 32'h7F);
      r_wdata = $urandom;
      r_err   = model_err(r_we, r_f3, r_addr);
      r_rdata = (!r_err && !r_we) ? model_load(r_f3, r_addr) : 32'h0;
      r_lat   = r_err ? 1 : ((r_we && r_f3 != 3'b010) ? 3 : 2);
      checkTxn("rand", r_we, r_f3, r_addr, r_wdata, r_rdata, r_err, r_lat,
               model_store_word(r_f3, r_addr, r_wdata));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
    end

`ifdef LSU_PERF_CNT_EN
    @(negedge clk);
    checkOutput("cnt_load", cnt_load, ref_loads);
    checkOutput("cnt_store", cnt_store, ref_stores);
    checkOutput("cnt_err", cnt_err, ref_errs);
`endif

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
